branch_resolve_unit: RTL and testbench

- Sits between the branch functional units (execute stage) and the branch stack.
- Collects branch execution results and detects mispredictions.
- Buffers results and emits at most one BRANCH_REG_PACKET per cycle on branch_completing. This is the packet the branch stack consumes to free or squash checkpoints.
- Keeps its own queue consistent with what it emits:
  - purges results made stale by an emitted mispredict;
  - clears resolved mask bits from the dependence masks of queued results.

---
 rtl/branch_resolve_unit_pkg.sv | 50 +++++
 rtl/branch_resolve_unit_if.sv | 31 +++
 rtl/branch_resolve_unit_brq_select.sv | 48 ++++
 rtl/branch_resolve_unit.sv | 133 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: FU result packets, the packet
// handed to the branch stack, and the resolution queue entry.
package branch_resolve_unit_pkg;

  localparam int B_MASK_WIDTH = 4;

  typedef logic [B_MASK_WIDTH-1:0] b_mask_t;

  // One branch result as produced by a branch functional unit.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    b_mask_t     bmm;          // one-hot mask bit owned by this branch
    b_mask_t     b_mask;       // mask bits of older unresolved branches
    logic        taken;
    logic [31:0] target;
    logic        pred_taken;
    logic [31:0] pred_target;
  } br_result_packet_t;

  // Resolution notice consumed by the branch stack.
  typedef struct packed {
    logic        valid;
    b_mask_t     bmm;
    logic        bm_mispred;
    logic [31:0] PC_correct;
  } branch_reg_packet_t;

  // Queue entry: only what is still needed once the outcome is known.
  typedef struct packed {
    logic        valid;
    b_mask_t     bmm;
    b_mask_t     b_mask;
    logic        mispred;
    logic [31:0] pc_correct;
  } brq_entry_t;

  // Resolve a raw FU result into a queue entry: mispredict flag and the
  // address fetch must continue from.
  function automatic brq_entry_t resolve_result(br_result_packet_t r);
    brq_entry_t e;
    e.valid      = r.valid;
    e.bmm        = r.bmm;
    e.b_mask     = r.b_mask;
    e.mispred    = (r.taken != r.pred_taken) | (r.taken & (r.target != r.pred_target));
    e.pc_correct = r.taken ? r.target : r.pc + 32'd4;
    return e;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bus between the branch FUs / branch stack and the resolve unit.
interface branch_resolve_unit_if #(
  parameter int N_BR_FU   = 2,
  parameter int BRQ_DEPTH = 4
);
  import branch_resolve_unit_pkg::*;

  localparam int CNT_W = $clog2(BRQ_DEPTH + 1);

  br_result_packet_t  br_results [N_BR_FU];
  logic               br_stall;
  branch_reg_packet_t branch_completing;
  logic [CNT_W-1:0]   brq_count;

  // Environment side: FUs drive results, branch stack consumes completions.
  modport master (
    output br_results,
    input  br_stall,
    input  branch_completing,
    input  brq_count
  );

  // Resolve unit side.
  modport slave (
    input  br_results,
    output br_stall,
    output branch_completing,
    output brq_count
  );

endinterface

// File: rtl/branch_resolve_unit_brq_select.sv
// Picks the entry to resolve this cycle: the oldest mispredict if any exists,
// otherwise the queue head. Purely combinational, one-hot result.
module branch_resolve_unit_brq_select
  import branch_resolve_unit_pkg::*;
#(
  parameter int BRQ_DEPTH = 4
) (
  input  logic [BRQ_DEPTH-1:0] valid_i,
  input  logic [BRQ_DEPTH-1:0] mispred_i,
  input  b_mask_t              bmm_i    [BRQ_DEPTH],
  input  b_mask_t              b_mask_i [BRQ_DEPTH],
  output logic [BRQ_DEPTH-1:0] sel_oh_o,
  output logic                 found_o
);

  b_mask_t mp_bits;

  // Gather the mask bits owned by every queued mispredicting branch.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see
    // the value just computed, exactly like wires in a chain.
    mp_bits = '0;
    for (int i = 0; i < BRQ_DEPTH; i++) begin
      if (valid_i[i] && mispred_i[i]) mp_bits = mp_bits | bmm_i[i];
    end
  end

  // A mispredict that depends on no other queued mispredict is the oldest;
  // ties go to the lowest index. Fall back to the head otherwise.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    sel_oh_o = '0;
    found_o  = 1'b0;
    for (int i = 0; i < BRQ_DEPTH; i++) begin
      if (!found_o && valid_i[i] && mispred_i[i] &&
          ((b_mask_i[i] & mp_bits & ~bmm_i[i]) == '0)) begin
        sel_oh_o[i] = 1'b1;
        found_o     = 1'b1;
      end
    end
    if (!found_o && valid_i[0]) begin
      sel_oh_o[0] = 1'b1;
      found_o     = 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues FU branch results, emits one resolution per
// cycle to the branch stack, and keeps its queue consistent with each
// emitted resolution (squash on mispredict, mask clear on correct).
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int N_BR_FU   = 2,
  parameter int BRQ_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  branch_resolve_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(BRQ_DEPTH + 1);
  // Stall once fewer than N_BR_FU slots are free.
  localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(BRQ_DEPTH - N_BR_FU + 1);

  brq_entry_t         queue_q [BRQ_DEPTH];
  brq_entry_t         queue_d [BRQ_DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  branch_reg_packet_t out_q, out_d;

  logic [BRQ_DEPTH-1:0] q_valid, q_mispred;
  b_mask_t              q_bmm    [BRQ_DEPTH];
  b_mask_t              q_b_mask [BRQ_DEPTH];
  logic [BRQ_DEPTH-1:0] sel_oh;
  logic                 sel_found;
  brq_entry_t           sel_e;
  logic                 stall;
  logic                 squash;
  b_mask_t              res_mask;

  // Occupancy before this cycle's removal: conservative but needs no bypass.
  assign stall = (count_q >= STALL_AT);

  // Expose just the fields the picker needs.
  always_comb begin
    for (int i = 0; i < BRQ_DEPTH; i++) begin
      q_valid[i]   = queue_q[i].valid;
      q_mispred[i] = queue_q[i].mispred;
      q_bmm[i]     = queue_q[i].bmm;
      q_b_mask[i]  = queue_q[i].b_mask;
    end
  end

  branch_resolve_unit_brq_select #(
    .BRQ_DEPTH (BRQ_DEPTH)
  ) u_select (
    .valid_i   (q_valid),
    .mispred_i (q_mispred),
    .bmm_i     (q_bmm),
    .b_mask_i  (q_b_mask),
    .sel_oh_o  (sel_oh),
    .found_o   (sel_found)
  );

  // Mux out the selected entry and build the outgoing packet.
  always_comb begin
    sel_e = '0;
    for (int i = 0; i < BRQ_DEPTH; i++) begin
      if (sel_oh[i]) sel_e = queue_q[i];
    end
    squash   = sel_found & sel_e.mispred;
    res_mask = sel_found ? sel_e.bmm : '0;

    out_d = '0;
    if (sel_found) begin
      out_d.valid      = 1'b1;
      out_d.bmm        = sel_e.bmm;
      out_d.bm_mispred = sel_e.mispred;
      out_d.PC_correct = sel_e.pc_correct;
    end
  end

  // Collapse survivors toward index 0, then append accepted results in port
  // order. On a squash no survivor carries res_mask, so clearing it is
  // harmless and keeps one code path.
  always_comb begin
    int         wr;
    brq_entry_t e;
    wr = 0;
    e  = '0;
    for (int j = 0; j < BRQ_DEPTH; j++) queue_d[j] = '0;

    for (int i = 0; i < BRQ_DEPTH; i++) begin
      if (queue_q[i].valid && !sel_oh[i] &&
          !(squash && ((queue_q[i].b_mask & res_mask) != '0))) begin
        e        = queue_q[i];
        e.b_mask = e.b_mask & ~res_mask;
        for (int j = 0; j < BRQ_DEPTH; j++) begin
          if (j == wr) queue_d[j] = e;
        end
        wr = wr + 1;
      end
    end

    if (!stall) begin
      for (int p = 0; p < N_BR_FU; p++) begin
        e = resolve_result(bus.br_results[p]);
        if (e.valid && !(squash && ((e.b_mask & res_mask) != '0))) begin
          e.b_mask = e.b_mask & ~res_mask;
          for (int j = 0; j < BRQ_DEPTH; j++) begin
            if (j == wr) queue_d[j] = e;
          end
          wr = wr + 1;
        end
      end
    end

    count_d = wr[CNT_W-1:0];
  end

  // State registers: queue, occupancy and the registered completion packet.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the queue is only a few entries, so it is cleared outright;
      // a larger store would reset just the valid bits and use '<=' the same.
      for (int i = 0; i < BRQ_DEPTH; i++) queue_q[i] <= '0;
      count_q <= '0;
      out_q   <= '0;
    end else begin
      queue_q <= queue_d;
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

  assign bus.br_stall          = stall;
  assign bus.branch_completing = out_q;
  assign bus.brq_count         = count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases followed by
// random traffic, checked by a queue-based reference model and scoreboard.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  branch_resolve_unit_if #(.N_BR_FU(N), .BRQ_DEPTH(DEPTH)) dut_if ();

  branch_resolve_unit #(.N_BR_FU(N), .BRQ_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (dut_if)
  );

  // Reference model state: a queue of outstanding resolved branches.
  typedef struct packed {
    b_mask_t     bmm;
    b_mask_t     b_mask;
    logic        mispred;
    logic [31:0] pc_correct;
  } m_entry_t;

  typedef struct packed {
    logic        valid;
    b_mask_t     bmm;
    logic        mispred;
    logic [31:0] pc;
  } m_out_t;

  m_entry_t          mq[$];
  m_out_t            exp_q[$];
  br_result_packet_t cur_in [N];
  int                n_cmp  = 0;
  int                n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of the model: choose the branch to report, retire it, apply
  // its squash or mask release, then accept new results if there was room.
  function automatic void model_step(input bit rst);
    int       sel;
    b_mask_t  mp_bits;
    b_mask_t  m;
    bit       have, squash, full;
    m_out_t   o;
    m_entry_t e;
    m_entry_t keep[$];
    if (rst) begin
      mq.delete();
      exp_q.push_back('0);
      return;
    end
    full    = (mq.size() > DEPTH - N);
    mp_bits = '0;
    foreach (mq[i]) if (mq[i].mispred) mp_bits |= mq[i].bmm;
    sel = -1;
    foreach (mq[i]) begin
      if (sel < 0 && mq[i].mispred && ((mq[i].b_mask & mp_bits & ~mq[i].bmm) == '0)) sel = i;
    end
    if (sel < 0 && mq.size() > 0) sel = 0;
    have   = (sel >= 0);
    o      = '0;
    m      = '0;
    squash = 1'b0;
    if (have) begin
      o.valid   = 1'b1;
      o.bmm     = mq[sel].bmm;
      o.mispred = mq[sel].mispred;
      o.pc      = mq[sel].pc_correct;
      m         = mq[sel].bmm;
      squash    = mq[sel].mispred;
    end
    exp_q.push_back(o);
    foreach (mq[i]) begin
      if (i != sel && !(squash && ((mq[i].b_mask & m) != '0))) begin
        e = mq[i];
        if (!squash) e.b_mask &= ~m;
        keep.push_back(e);
      end
    end
    mq = keep;
    if (!full) begin
      for (int p = 0; p < N; p++) begin
        if (cur_in[p].valid && !(squash && ((cur_in[p].b_mask & m) != '0))) begin
          e.bmm        = cur_in[p].bmm;
          e.b_mask     = squash ? cur_in[p].b_mask : (cur_in[p].b_mask & ~m);
          // wrong direction, or right direction but wrong taken target
          e.mispred    = (cur_in[p].taken != cur_in[p].pred_taken) ||
                         (cur_in[p].taken && (cur_in[p].target != cur_in[p].pred_target));
          e.pc_correct = cur_in[p].taken ? cur_in[p].target : cur_in[p].pc + 32'd4;
          mq.push_back(e);
        end
      end
    end
  endfunction

  // Drive one cycle of stimulus; check stall/occupancy away from the edge.
  task automatic step(input bit rst);
    @(negedge clock);
    check("br_stall", 32'(dut_if.br_stall), 32'(mq.size() > DEPTH - N));
    check("brq_count", 32'(dut_if.brq_count), 32'(mq.size()));
    reset = rst;
    for (int p = 0; p < N; p++) dut_if.br_results[p] = cur_in[p];
    model_step(rst);
  endtask

  task automatic clear_in();
    for (int p = 0; p < N; p++) cur_in[p] = '0;
  endtask

  task automatic idle(input int n);
    clear_in();
    for (int k = 0; k < n; k++) step(1'b0);
  endtask

  function automatic br_result_packet_t mk(input logic [31:0] pc, input b_mask_t bmm,
                                           input b_mask_t bm, input logic tk,
                                           input logic [31:0] tg, input logic ptk,
                                           input logic [31:0] ptg);
    br_result_packet_t r;
    r.valid = 1'b1; r.pc = pc; r.bmm = bmm; r.b_mask = bm;
    r.taken = tk; r.target = tg; r.pred_taken = ptk; r.pred_target = ptg;
    return r;
  endfunction

  // Random stimulus with mask bits that are unique among in-flight branches.
  task automatic rand_cycle();
    b_mask_t live, used;
    bit      full;
    int      start, idx;
    bit      got;
    live = '0;
    used = '0;
    foreach (mq[i]) live |= mq[i].bmm;
    full = (mq.size() > DEPTH - N);
    for (int p = 0; p < N; p++) begin
      br_result_packet_t r;
      r = '0;
      if ($urandom_range(0, 99) < 65) begin
        start = $urandom_range(0, B_MASK_WIDTH - 1);
        got   = 1'b0;
        for (int k = 0; k < B_MASK_WIDTH; k++) begin
          idx = (start + k) % B_MASK_WIDTH;
          if (!got && (full || (!live[idx] && !used[idx]))) begin
            r.bmm = b_mask_t'(1) << idx;
            got   = 1'b1;
          end
        end
        r.valid       = got;
        r.b_mask      = (live | used) & b_mask_t'($urandom) & ~r.bmm;
        r.pc          = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & ~32'd3);
        r.taken       = 1'($urandom_range(0, 1));
        r.pred_taken  = ($urandom_range(0, 99) < 75) ? r.taken : ~r.taken;
        r.target      = $urandom & ~32'd3;
        r.pred_target = ($urandom_range(0, 99) < 80) ? r.target : ($urandom & ~32'd3);
        if (!full) used |= r.bmm;
      end
      cur_in[p] = r;
    end
    step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
  endtask

  // Scoreboard monitor: every cycle the registered packet must match the
  // model's prediction for that edge, including all-zero when idle.
  initial begin
    m_out_t e;
    forever begin
      @(posedge clock);
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("out.valid", 32'(dut_if.branch_completing.valid), 32'(e.valid));
      check("out.bmm", 32'(dut_if.branch_completing.bmm), 32'(e.bmm));
      check("out.bm_mispred", 32'(dut_if.branch_completing.bm_mispred), 32'(e.mispred));
      check("out.PC_correct", dut_if.branch_completing.PC_correct, e.pc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_in();
    reset = 1'b1;
    for (int p = 0; p < N; p++) dut_if.br_results[p] = cur_in[p];
    model_step(1'b1);
    clear_in();
    step(1'b1);
    step(1'b1);
    idle(2);

    // Correctly predicted taken branch.
    cur_in[0] = mk(32'h80, 4'b0001, 4'b0000, 1'b1, 32'h100, 1'b1, 32'h100);
    step(1'b0);
    idle(4);

    // Direction mispredict: falls through to pc+4.
    cur_in[0] = mk(32'h40, 4'b0001, 4'b0000, 1'b0, 32'h200, 1'b1, 32'h200);
    step(1'b0);
    idle(4);

    // Two mispredicts together: the older one squashes the younger.
    cur_in[0] = mk(32'h10, 4'b0001, 4'b0000, 1'b0, 32'h300, 1'b1, 32'h300);
    cur_in[1] = mk(32'h20, 4'b0010, 4'b0001, 1'b1, 32'h400, 1'b0, 32'h400);
    step(1'b0);
    idle(4);

    // Correct resolution clears the dependent's mask bit.
    cur_in[0] = mk(32'h30, 4'b0001, 4'b0000, 1'b1, 32'h500, 1'b1, 32'h500);
    cur_in[1] = mk(32'h34, 4'b0010, 4'b0001, 1'b0, 32'h600, 1'b0, 32'h600);
    step(1'b0);
    idle(4);

    // Fill to the stall threshold, then offer results that must be ignored.
    cur_in[0] = mk(32'h100, 4'b0001, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    cur_in[1] = mk(32'h104, 4'b0010, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0);
    cur_in[0] = mk(32'h108, 4'b0100, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    cur_in[1] = mk(32'h10C, 4'b1000, 4'b0000, 1'b1, 32'h700, 1'b1, 32'h700);
    step(1'b0);
    cur_in[0] = mk(32'h110, 4'b0001, 4'b0000, 1'b0, 32'h0, 1'b1, 32'h0);
    cur_in[1] = mk(32'h114, 4'b0010, 4'b0000, 1'b0, 32'h0, 1'b1, 32'h0);
    step(1'b0);
    idle(6);

    // Reset with three entries queued and an output pending.
    cur_in[0] = mk(32'h200, 4'b0001, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    cur_in[1] = mk(32'h204, 4'b0010, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0);
    cur_in[0] = mk(32'h208, 4'b0100, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    cur_in[1] = mk(32'h20C, 4'b1000, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0);
    cur_in[0] = mk(32'h210, 4'b0001, 4'b0000, 1'b0, 32'h0, 1'b1, 32'h0);
    step(1'b1);
    idle(3);

    // Random traffic.
    for (int c = 0; c < 3000; c++) rand_cycle();
    idle(10);

    @(posedge clock);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
